// File: rtl/wave_pkg.sv
// Shared types and constants for the DDS wave sequencer: waveform codes, the segment
// record held in the FIFO, and the sequencer state encoding.
package wave_pkg;

    localparam int PHASE_W   = 12;
    localparam int SEG_DIV_W = 16;
    localparam int SEG_DUR_W = 16;

    localparam logic [1:0] SEL_OFF    = 2'd0;
    localparam logic [1:0] SEL_SQUARE = 2'd1;
    localparam logic [1:0] SEL_SAW    = 2'd2;
    localparam logic [1:0] SEL_TRI    = 2'd3;

    typedef struct packed {
        logic [1:0]           sel;
        logic [SEG_DIV_W-1:0] div;
        logic [SEG_DUR_W-1:0] dur;
    } seg_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // A zero duration still plays one full period.
    function automatic logic [SEG_DUR_W-1:0] eff_dur(input logic [SEG_DUR_W-1:0] dur);
        if (dur == '0) begin
            eff_dur = {{(SEG_DUR_W-1){1'b0}}, 1'b1};
        end else begin
            eff_dur = dur;
        end
    endfunction

endpackage

// File: rtl/wave_seq_ctrl_seg_fifo.sv
// Synchronous segment FIFO with occupancy count; a reset empties it by clearing the pointers.
module seg_fifo
    import wave_pkg::*;
#(
    parameter int DEPTH = 4
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  seg_t                     i_data,
    output seg_t                     o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    seg_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            w_wr_en;
    logic            w_rd_en;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];
    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/wave_seq_ctrl.sv
// Segment sequencer for wave_gen: plays queued {sel, div, dur} segments back-to-back and
// keeps a shadow of the generator phase so sel only ever changes at a phase wrap.
module wave_seq_ctrl
    import wave_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DIV_W   = SEG_DIV_W,
    parameter int DUR_W   = SEG_DUR_W,
    parameter int PHASE_W = wave_pkg::PHASE_W
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [1:0]               cfg_sel,
    input  logic [DIV_W-1:0]         cfg_div,
    input  logic [DUR_W-1:0]         cfg_dur,
    input  logic                     start,
    input  logic                     stop,
    output logic                     divider,
    output logic [1:0]               sel,
    output logic                     busy,
    output logic                     seg_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    state_t             r_state;
    state_t             w_next;
    seg_t               w_head;
    seg_t               w_wdata;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         r_sel;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_presc;
    logic [DUR_W-1:0]   r_dur;
    logic [DUR_W-1:0]   r_cnt;
    logic [PHASE_W-1:0] r_phase;
    logic               r_stop_pend;
    logic               w_tick;
    logic               w_wrap;
    logic               w_last;
    logic               w_seg_end;
    logic               w_advance;

    assign w_wdata   = '{sel: cfg_sel, div: cfg_div, dur: cfg_dur};
    assign w_push    = cfg_valid && !w_full;
    assign cfg_ready = !w_full;
    assign sel       = r_sel;

    assign w_tick    = (r_state == ST_RUN) && (r_presc == r_div);
    assign w_wrap    = w_tick && (r_phase == {PHASE_W{1'b1}});
    assign w_last    = ({1'b0, r_cnt} + (DUR_W+1)'(1)) >= {1'b0, eff_dur(r_dur)};
    assign w_seg_end = w_wrap && (w_last || r_stop_pend);
    // Chaining into the next segment happens in the wrap cycle itself, so there is no gap.
    assign w_advance = w_seg_end && !w_empty && !r_stop_pend;

    seg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_wdata),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a stop alongside start in IDLE keeps the sequencer idle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop && !w_empty) w_next = ST_LOAD;
                else                            w_next = ST_IDLE;
            end
            ST_LOAD: w_next = ST_RUN;
            ST_RUN: begin
                if (w_seg_end && !w_advance) w_next = ST_IDLE;
                else                         w_next = ST_RUN;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode from the registered state and counters.
    always_comb begin
        w_pop    = 1'b0;
        divider  = 1'b0;
        seg_done = 1'b0;
        busy     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_pop = 1'b1;
                busy  = 1'b1;
            end
            ST_RUN: begin
                w_pop    = w_advance;
                divider  = w_tick;
                seg_done = w_seg_end;
                busy     = 1'b1;
            end
            default: begin
                w_pop = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    // Active segment, prescaler, period count and shadow phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= SEL_OFF;
            r_div   <= '0;
            r_dur   <= '0;
            r_presc <= '0;
            r_cnt   <= '0;
            r_phase <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_sel   <= w_head.sel;
                    r_div   <= w_head.div;
                    r_dur   <= w_head.dur;
                    r_presc <= '0;
                    r_cnt   <= '0;
                end
                ST_RUN: begin
                    if (w_tick) begin
                        r_presc <= '0;
                        r_phase <= r_phase + PHASE_W'(1);
                    end else begin
                        r_presc <= r_presc + DIV_W'(1);
                    end
                    if (w_seg_end) begin
                        r_cnt <= '0;
                        if (w_advance) begin
                            r_sel <= w_head.sel;
                            r_div <= w_head.div;
                            r_dur <= w_head.dur;
                        end else begin
                            r_sel <= SEL_OFF;
                        end
                    end else if (w_wrap) begin
                        r_cnt <= r_cnt + DUR_W'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                default: r_sel <= SEL_OFF;
            endcase
        end
    end

    // Pending graceful stop, armed only while playing and dropped on the way back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stop_pend <= 1'b0;
        end else if (w_next == ST_IDLE) begin
            r_stop_pend <= 1'b0;
        end else if (stop && (r_state != ST_IDLE)) begin
            r_stop_pend <= 1'b1;
        end else begin
            r_stop_pend <= r_stop_pend;
        end
    end

endmodule
